// File: rtl/vx_hamming_dec.sv
// -----------------------------------------------------------------------------
// vx_hamming_dec
// Two-stage SECDED Hamming decoder. It has valid/ready handshakes on both
// sides and two 16-bit saturating error counters.
//
// Codeword layout: index i holds position i+1. Position 2^k is check bit k.
// The remaining positions below ENCODED_BITS hold the payload in ascending
// order. The top index holds even parity over all lower bits.
//
// Stage 1 registers the codeword, its syndrome S and its overall parity P.
// Stage 2 classifies the word, corrects it and registers the payload and the
// error flags, which drive the outputs directly.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   valid_in    in   codeword present on encoded_in
//   ready_in    out  decoder accepts the codeword this cycle
//   encoded_in  in   [ENCODED_BITS-1:0] codeword
//   valid_out   out  result present
//   ready_out   in   consumer accepts the result
//   data_out    out  [DATA_BITS-1:0] corrected payload
//   err_single  out  one bit was corrected (or the parity bit was wrong)
//   err_double  out  uncorrectable error, payload passed through uncorrected
//   cnt_clear   in   synchronous clear of both counters (wins over increments)
//   cnt_single  out  [15:0] saturating count of delivered single errors
//   cnt_double  out  [15:0] saturating count of delivered double errors
// -----------------------------------------------------------------------------
module vx_hamming_dec #(
    parameter int DATA_BITS    = 32'd15,
    // smallest h with 2^h >= h + DATA_BITS + 1
    parameter int HAMMING_BITS =
        ((32'd1 << 32'd1)  >= (32'd1  + DATA_BITS + 32'd1)) ? 32'd1  :
        ((32'd1 << 32'd2)  >= (32'd2  + DATA_BITS + 32'd1)) ? 32'd2  :
        ((32'd1 << 32'd3)  >= (32'd3  + DATA_BITS + 32'd1)) ? 32'd3  :
        ((32'd1 << 32'd4)  >= (32'd4  + DATA_BITS + 32'd1)) ? 32'd4  :
        ((32'd1 << 32'd5)  >= (32'd5  + DATA_BITS + 32'd1)) ? 32'd5  :
        ((32'd1 << 32'd6)  >= (32'd6  + DATA_BITS + 32'd1)) ? 32'd6  :
        ((32'd1 << 32'd7)  >= (32'd7  + DATA_BITS + 32'd1)) ? 32'd7  :
        ((32'd1 << 32'd8)  >= (32'd8  + DATA_BITS + 32'd1)) ? 32'd8  :
        ((32'd1 << 32'd9)  >= (32'd9  + DATA_BITS + 32'd1)) ? 32'd9  :
        ((32'd1 << 32'd10) >= (32'd10 + DATA_BITS + 32'd1)) ? 32'd10 : 32'd11,
    parameter int ENCODED_BITS = DATA_BITS + HAMMING_BITS + 32'd1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [ENCODED_BITS-1:0] encoded_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_BITS-1:0]    data_out,
    output logic                    err_single,
    output logic                    err_double,
    input  logic                    cnt_clear,
    output logic [15:0]             cnt_single,
    output logic [15:0]             cnt_double
);

    // Highest position covered by the syndrome; larger syndromes point
    // outside the codeword and can only come from multiple errors.
    localparam logic [HAMMING_BITS-1:0] MAX_POS = HAMMING_BITS'(ENCODED_BITS - 32'd1);

    // XOR of the position numbers of every set bit below the parity bit.
    function automatic logic [HAMMING_BITS-1:0] calc_syndrome(input logic [ENCODED_BITS-1:0] cw);
        logic [HAMMING_BITS-1:0] syn;
        syn = '0;
        for (int i = 0; i < ENCODED_BITS - 1; i++) begin
            if (cw[i]) begin
                syn = syn ^ HAMMING_BITS'(i + 32'd1);
            end else begin
                syn = syn;
            end
        end
        return syn;
    endfunction

    // Overall parity across the full codeword, including the parity bit.
    function automatic logic calc_parity(input logic [ENCODED_BITS-1:0] cw);
        return ^cw;
    endfunction

    // Collect the payload from every non-power-of-two position, lowest first.
    function automatic logic [DATA_BITS-1:0] extract_data(input logic [ENCODED_BITS-1:0] cw);
        logic [DATA_BITS-1:0] data;
        int                   k;
        data = '0;
        k    = 0;
        for (int i = 0; i < ENCODED_BITS - 1; i++) begin
            // position i+1 is a power of two exactly when (i+1) & i == 0
            if ((((i + 32'd1) & i) != 32'd0) && (k < DATA_BITS)) begin
                data[k] = cw[i];
                k       = k + 1;
            end else begin
                data = data;
            end
        end
        return data;
    endfunction

    logic                    r_s1_valid;
    logic [ENCODED_BITS-1:0] r_s1_cw;
    logic [HAMMING_BITS-1:0] r_s1_syn;
    logic                    r_s1_par;
    logic                    r_s2_valid;
    logic [DATA_BITS-1:0]    r_data;
    logic                    r_err_single;
    logic                    r_err_double;
    logic [15:0]             r_cnt_single;
    logic [15:0]             r_cnt_double;

    logic                    w_s2_free;
    logic                    w_s1_adv;
    logic                    w_ready_in;
    logic                    w_s1_load;
    logic                    w_out_hs;
    logic [HAMMING_BITS-1:0] w_in_syn;
    logic                    w_in_par;
    logic [ENCODED_BITS-1:0] w_fix_cw;
    logic [DATA_BITS-1:0]    w_fix_data;
    logic                    w_flag_single;
    logic                    w_flag_double;

    // Elastic control. ready_in only looks at pipeline state and ready_out,
    // so there is no combinational path from valid_in to ready_in.
    assign w_s2_free  = !r_s2_valid || ready_out;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign w_ready_in = !r_s1_valid || w_s1_adv;
    assign w_s1_load  = valid_in && w_ready_in;
    assign w_out_hs   = r_s2_valid && ready_out;

    assign w_in_syn   = calc_syndrome(encoded_in);
    assign w_in_par   = calc_parity(encoded_in);

    // Classify the stage-1 word and flip the erroneous bit when it is correctable.
    always_comb begin
        w_fix_cw      = r_s1_cw;
        w_flag_single = 1'b0;
        w_flag_double = 1'b0;
        if (r_s1_par) begin
            if (r_s1_syn == '0) begin
                // only the overall parity bit is wrong; payload is intact
                w_flag_single = 1'b1;
            end else if (r_s1_syn <= MAX_POS) begin
                w_flag_single = 1'b1;
                for (int i = 0; i < ENCODED_BITS - 1; i++) begin
                    if (HAMMING_BITS'(i + 32'd1) == r_s1_syn) begin
                        w_fix_cw[i] = ~r_s1_cw[i];
                    end else begin
                        w_fix_cw[i] = r_s1_cw[i];
                    end
                end
            end else begin
                w_flag_double = 1'b1;
            end
        end else begin
            if (r_s1_syn != '0) begin
                w_flag_double = 1'b1;
            end else begin
                w_flag_double = 1'b0;
            end
        end
    end

    assign w_fix_data = extract_data(w_fix_cw);

    // Stage 1: capture the codeword together with its syndrome and parity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else begin
            if (w_ready_in) begin
                r_s1_valid <= valid_in;
            end
            if (w_s1_load) begin
                r_s1_cw  <= encoded_in;
                r_s1_syn <= w_in_syn;
                r_s1_par <= w_in_par;
            end
        end
    end

    // Stage 2: register the corrected payload and flags; they hold while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid   <= 1'b0;
            r_data       <= '0;
            r_err_single <= 1'b0;
            r_err_double <= 1'b0;
        end else begin
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv) begin
                r_data       <= w_fix_data;
                r_err_single <= w_flag_single;
                r_err_double <= w_flag_double;
            end
        end
    end

    // Error counters: count delivered words only, saturate, clear has priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_single <= 16'h0000;
            r_cnt_double <= 16'h0000;
        end else if (cnt_clear) begin
            r_cnt_single <= 16'h0000;
            r_cnt_double <= 16'h0000;
        end else begin
            if (w_out_hs && r_err_single && (r_cnt_single != 16'hFFFF)) begin
                r_cnt_single <= r_cnt_single + 16'd1;
            end
            if (w_out_hs && r_err_double && (r_cnt_double != 16'hFFFF)) begin
                r_cnt_double <= r_cnt_double + 16'd1;
            end
        end
    end

    assign ready_in   = w_ready_in;
    assign valid_out  = r_s2_valid;
    assign data_out   = r_data;
    assign err_single = r_err_single;
    assign err_double = r_err_double;
    assign cnt_single = r_cnt_single;
    assign cnt_double = r_cnt_double;

endmodule

// File: tb/tb_vx_hamming_dec.sv
// -----------------------------------------------------------------------------
// tb_vx_hamming_dec
// Self-checking bench for vx_hamming_dec with its default parameters.
// The reference model encodes payloads straight from the codeword layout and
// predicts each result from the number of bits it flipped:
//   0 flips -> payload, no flags
//   1 flip  -> payload, err_single
//   2 flips -> payload as read from the corrupted word, err_double
// -----------------------------------------------------------------------------
module tb_vx_hamming_dec;

    localparam int D  = 15;
    localparam int H  = 5;
    localparam int EB = 21;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_out = 1'b1;
    logic          cnt_clear = 1'b0;
    logic [EB-1:0] encoded_in = '0;
    logic          ready_in;
    logic          valid_out;
    logic [D-1:0]  data_out;
    logic          err_single;
    logic          err_double;
    logic [15:0]   cnt_single;
    logic [15:0]   cnt_double;

    typedef struct packed {
        logic [D-1:0] data;
        logic         es;
        logic         ed;
    } res_t;

    res_t obs_q[$];
    res_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_cs = 0;
    int   exp_cd = 0;
    logic rec_en = 1'b1;
    logic rnd_done = 1'b0;

    vx_hamming_dec dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .encoded_in (encoded_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .err_single (err_single),
        .err_double (err_double),
        .cnt_clear  (cnt_clear),
        .cnt_single (cnt_single),
        .cnt_double (cnt_double)
    );

    always #5 clk = ~clk;

    // Record every delivered result (handshake happens at the following edge).
    always @(negedge clk) begin
        if (rec_en && reset && valid_out && ready_out)
            obs_q.push_back({data_out, err_single, err_double});
    end

    function automatic logic is_pow2(input int p);
        return $countones(p) == 1;
    endfunction

    // Reference encoder: place the payload, then choose the check bits so that
    // the syndrome of the whole word becomes zero, then set the even parity.
    function automatic logic [EB-1:0] enc(input logic [D-1:0] d);
        logic [EB-1:0] cw;
        int k;
        int s;
        cw = '0; k = 0; s = 0;
        for (int p = 1; p < EB; p++)
            if (!is_pow2(p)) begin cw[p-1] = d[k]; k++; end
        for (int p = 1; p < EB; p++)
            if (cw[p-1]) s = s ^ p;
        for (int j = 0; j < H; j++)
            cw[(1 << j) - 1] = s[j];
        cw[EB-1] = ^cw[EB-2:0];
        return cw;
    endfunction

    function automatic logic [D-1:0] ext(input logic [EB-1:0] cw);
        logic [D-1:0] d;
        int k;
        d = '0; k = 0;
        for (int p = 1; p < EB; p++)
            if (!is_pow2(p)) begin d[k] = cw[p-1]; k++; end
        return d;
    endfunction

    // Build a random word with nerr distinct flipped bits, queue its expected result.
    task automatic queue_word(input int nerr, output logic [EB-1:0] cw);
        logic [D-1:0] d;
        res_t e;
        int a, b;
        d  = D'($urandom);
        cw = enc(d);
        a  = $urandom_range(0, EB-1);
        b  = a;
        if (nerr >= 1) cw[a] = ~cw[a];
        if (nerr >= 2) begin
            while (b == a) b = $urandom_range(0, EB-1);
            cw[b] = ~cw[b];
        end
        if (nerr == 0)      e = {d, 1'b0, 1'b0};
        else if (nerr == 1) e = {d, 1'b1, 1'b0};
        else                e = {ext(cw), 1'b0, 1'b1};
        exp_q.push_back(e);
        if (nerr == 1 && exp_cs < 65535) exp_cs++;
        if (nerr == 2 && exp_cd < 65535) exp_cd++;
    endtask

    // Offer cw until accepted (called and returning at posedge+1), bounded.
    task automatic send(input logic [EB-1:0] cw);
        logic ok;
        ok = 1'b0;
        valid_in   = 1'b1;
        encoded_in = cw;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            ok = ready_in;
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: ready_in stayed 0, required 1 within 500 cycles");
        end
    endtask

    task automatic wait_obs(input int n, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (obs_q.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (data_out !== 15'h0000) begin n_fail++; $display("FAIL reset_data_out: got %h want 0000", data_out); end
        n_cmp++; if ({err_single, err_double} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", err_single, err_double); end
        n_cmp++; if (cnt_single !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt_single: got %h want 0000", cnt_single); end
        n_cmp++; if (cnt_double !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt_double: got %h want 0000", cnt_double); end
        n_cmp++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b want 1", ready_in); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_latency();
        ready_out = 1'b1; valid_in = 1'b1; encoded_in = '0;
        @(negedge clk);
        n_cmp++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL zero_ready_in: got %b want 1", ready_in); end
        @(posedge clk); #1;            // handshake edge
        valid_in = 1'b0;
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL zero_latency_early: valid_out %b want 0 one cycle after handshake", valid_out); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL zero_latency: valid_out %b want 1 two cycles after handshake", valid_out); end
        n_cmp++; if ({data_out, err_single, err_double} !== {15'h0000, 2'b00}) begin
            n_fail++; $display("FAIL zero_result: got data=%h s=%b d=%b want 0000 0 0", data_out, err_single, err_double);
        end
        repeat (3) begin @(posedge clk); #1; end
        obs_q.delete();
    endtask

    task automatic test_single_error();
        logic [EB-1:0] cw;
        logic ok;
        res_t o;
        obs_q.delete();
        cw = enc(15'h7FFF);
        cw[2] = ~cw[2];
        send(cw);
        valid_in = 1'b0;
        wait_obs(1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout: no output, want 1 word"); end
        else begin
            o = obs_q.pop_front();
            n_cmp++; if (o !== {15'h7FFF, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL single_result: got data=%h s=%b d=%b want 7fff 1 0", o.data, o.es, o.ed);
            end
        end
        repeat (2) begin @(posedge clk); #1; end
        exp_cs = 1; exp_cd = 0;
        n_cmp++; if (cnt_single !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", cnt_single); end
    endtask

    task automatic test_double_error();
        logic [EB-1:0] cw;
        logic ok;
        res_t o;
        obs_q.delete();
        cw = enc(15'h1234);
        cw[2] = ~cw[2];
        cw[4] = ~cw[4];
        send(cw);
        cw = enc(15'h1234);
        cw[20] = ~cw[20];
        send(cw);
        valid_in = 1'b0;
        wait_obs(2, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL double_timeout: got %0d outputs want 2", obs_q.size()); end
        else begin
            // positions 3 and 5 carry payload bits 0 and 1, passed through uncorrected
            o = obs_q.pop_front();
            n_cmp++; if (o !== {15'h1237, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL double_result: got data=%h s=%b d=%b want 1237 0 1", o.data, o.es, o.ed);
            end
            o = obs_q.pop_front();
            n_cmp++; if (o !== {15'h1234, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL parity_bit_result: got data=%h s=%b d=%b want 1234 1 0", o.data, o.es, o.ed);
            end
        end
        repeat (2) begin @(posedge clk); #1; end
        exp_cs = 2; exp_cd = 1;
        n_cmp++; if (cnt_double !== 16'd1) begin n_fail++; $display("FAIL double_cnt: got %0d want 1", cnt_double); end
        n_cmp++; if (cnt_single !== 16'd2) begin n_fail++; $display("FAIL double_cnt_single: got %0d want 2", cnt_single); end
    endtask

    task automatic test_back_to_back();
        logic [EB-1:0] c0, c1, c2;
        logic ok;
        res_t held, cur, o, e;
        obs_q.delete(); exp_q.delete();
        queue_word($urandom_range(0, 2), c0);
        queue_word($urandom_range(0, 2), c1);
        queue_word($urandom_range(0, 2), c2);
        ready_out = 1'b0; valid_in = 1'b1; encoded_in = c0;
        @(posedge clk); #1;
        encoded_in = c1;
        @(negedge clk);
        n_cmp++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL bb_ready_second: got %b want 1", ready_in); end
        @(posedge clk); #1;
        encoded_in = c2;
        @(negedge clk);
        n_cmp++; if (ready_in !== 1'b0) begin n_fail++; $display("FAIL bb_ready_low: got %b want 0 after two accepts", ready_in); end
        held = {data_out, err_single, err_double};
        n_cmp++; if (held !== exp_q[0]) begin n_fail++; $display("FAIL bb_first_held: got %h want %h", held, exp_q[0]); end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            cur = {data_out, err_single, err_double};
            n_cmp++; if ({valid_out, ready_in, cur} !== {1'b1, 1'b0, held}) begin
                n_fail++; $display("FAIL bb_stall_hold: got v=%b r=%b res=%h want 1 0 %h", valid_out, ready_in, cur, held);
            end
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        send(c2);
        valid_in = 1'b0;
        wait_obs(3, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bb_timeout: got %0d outputs want 3", obs_q.size()); end
        for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL bb_order word %0d: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_random();
        logic ok;
        res_t o, e;
        obs_q.delete(); exp_q.delete();
        rnd_done = 1'b0;
        fork
            begin
                logic [EB-1:0] cw;
                for (int i = 0; i < 300; i++) begin
                    queue_word($urandom_range(0, 2), cw);
                    send(cw);
                    if ($urandom_range(0, 3) == 0) begin
                        valid_in = 1'b0;
                        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    end
                end
                valid_in = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    ready_out = ($urandom_range(0, 9) < 7);
                    @(posedge clk); #1;
                end
                ready_out = 1'b1;
            end
        join
        wait_obs(300, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: got %0d outputs want 300", obs_q.size()); end
        for (int i = 0; i < 300 && obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin
                n_fail++; $display("FAIL rand_word %0d: got data=%h s=%b d=%b want data=%h s=%b d=%b", i, o.data, o.es, o.ed, e.data, e.es, e.ed);
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (cnt_single !== 16'(exp_cs)) begin n_fail++; $display("FAIL rand_cnt_single: got %0d want %0d", cnt_single, exp_cs); end
        n_cmp++; if (cnt_double !== 16'(exp_cd)) begin n_fail++; $display("FAIL rand_cnt_double: got %0d want %0d", cnt_double, exp_cd); end
    endtask

    task automatic test_saturation();
        logic [EB-1:0] cw;
        logic seen;
        rec_en = 1'b0; ready_out = 1'b1;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        n_cmp++; if ({cnt_single, cnt_double} !== 32'h0) begin n_fail++; $display("FAIL clear_cnts: got %h %h want 0 0", cnt_single, cnt_double); end
        for (int i = 0; i < 65540; i++) begin
            cw = enc(D'($urandom));
            cw[$urandom_range(0, EB-1)] ^= 1'b1;
            send(cw);
        end
        valid_in = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_cmp++; if (cnt_single !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt_single: got %h want ffff", cnt_single); end
        n_cmp++; if (cnt_double !== 16'h0000) begin n_fail++; $display("FAIL sat_cnt_double: got %h want 0000", cnt_double); end
        // clear collides with a single-error handshake, once saturated and once at zero
        for (int rep = 0; rep < 2; rep++) begin
            cw = enc(D'($urandom));
            cw[$urandom_range(0, EB-1)] ^= 1'b1;
            send(cw);
            valid_in = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                seen = valid_out;
            end
            cnt_clear = 1'b1;
            @(posedge clk); #1;
            cnt_clear = 1'b0;
            n_cmp++; if (!seen) begin n_fail++; $display("FAIL clear_collide_timeout %0d: valid_out never rose", rep); end
            @(posedge clk); #1;
            n_cmp++; if (cnt_single !== 16'h0000) begin n_fail++; $display("FAIL clear_collide %0d: cnt_single got %h want 0000", rep, cnt_single); end
        end
        exp_cs = 0; exp_cd = 0;
        rec_en = 1'b1;
        obs_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic [EB-1:0] cw;
        logic ok;
        res_t o, e;
        obs_q.delete(); exp_q.delete();
        ready_out = 1'b1;
        queue_word(1, cw); send(cw);
        queue_word(2, cw); send(cw);
        valid_in = 1'b0;
        wait_obs(2, ok);
        obs_q.delete(); exp_q.delete();
        ready_out = 1'b0;
        send(enc(D'($urandom)));
        send(enc(D'($urandom)));
        valid_in = 1'b0;
        @(negedge clk);
        n_cmp++; if ({valid_out, ready_in} !== 2'b10) begin n_fail++; $display("FAIL mid_full: got v=%b r=%b want 1 0", valid_out, ready_in); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid_out: got %b want 0", valid_out); end
        n_cmp++; if ({cnt_single, cnt_double} !== 32'h0) begin n_fail++; $display("FAIL mid_cnts: got %h %h want 0 0", cnt_single, cnt_double); end
        n_cmp++; if ({ready_in, data_out, err_single, err_double} !== {1'b1, 15'h0, 2'b00}) begin
            n_fail++; $display("FAIL mid_outputs: got r=%b data=%h s=%b d=%b want 1 0000 0 0", ready_in, data_out, err_single, err_double);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        ready_out = 1'b1;
        exp_cs = 0; exp_cd = 0;
        queue_word(1, cw);
        send(cw);
        valid_in = 1'b0;
        wait_obs(1, ok);
        repeat (4) begin @(posedge clk); #1; end
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL mid_count: got %0d outputs want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL mid_first_word: got %h want %h", o, e); end
        end
        n_cmp++; if (cnt_single !== 16'd1) begin n_fail++; $display("FAIL mid_cnt_single: got %0d want 1", cnt_single); end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_single_error();
        test_double_error();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
